// File: rtl/mac_pipe_pkg.sv
// ============================================================================
// mac_pipe_pkg : opcode encoding and width helper shared by the MAC pipeline
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mac_pipe_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MADD  = 2'b01,
    OP_MAC   = 2'b10,
    OP_MACLD = 2'b11
  } op_e;

  function automatic int acc_width(input int bits, input int guard);
    return 2 * bits + guard;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_pipe_mult.sv
// ============================================================================
// mac_mult : combinational BITS x BITS -> 2*BITS multiplier, signed or unsigned
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_mult #(
  parameter int BITS   = 32,
  parameter int SIGNED = 1
) (
  input  logic [BITS-1:0]   a_i,
  input  logic [BITS-1:0]   b_i,
  output logic [2*BITS-1:0] p_o
);

  logic [2*BITS-1:0] w_a;
  logic [2*BITS-1:0] w_b;

  // Operands are widened first so the truncated 2*BITS product is exact.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_a = (2*BITS)'($signed(a_i));
      assign w_b = (2*BITS)'($signed(b_i));
    end else begin : g_unsigned
      assign w_a = (2*BITS)'(a_i);
      assign w_b = (2*BITS)'(b_i);
    end
  endgenerate

  assign p_o = w_a * w_b;

endmodule

`default_nettype wire

// File: rtl/mac_pipe.sv
// ============================================================================
// mac_pipe : two-stage multiply / multiply-add / accumulate pipeline with
//            valid/ready handshakes; MAC_PIPE_SAT_EN enables MAC saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_pipe
  import mac_pipe_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int GUARD  = 8,
  parameter int SIGNED = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              func,
  input  logic [BITS-1:0]         a,
  input  logic [BITS-1:0]         b,
  input  logic [BITS-1:0]         c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*BITS+GUARD-1:0] result,
  output logic                    ovf
);

  localparam int AW = acc_width(BITS, GUARD);
  localparam int PW = 2 * BITS;

  logic              w_advance;
  logic [PW-1:0]     w_prod;
  logic [AW-1:0]     w_prod_ext;
  logic [AW-1:0]     w_c_ext;
  logic [AW:0]       w_acc_x;
  logic [AW:0]       w_prod_x;
  logic [AW:0]       w_sum_x;
  logic              w_mac_ovf;
  logic [AW-1:0]     w_mac_val;

  logic              s1_valid_q;
  logic [PW-1:0]     s1_prod_q;
  logic [BITS-1:0]   s1_c_q;
  op_e               s1_op_q;
  logic              s2_valid_q;
  logic [AW-1:0]     result_q, result_d;
  logic              ovf_q, ovf_d;
  logic [AW-1:0]     acc_q, acc_d;

  mac_mult #(
    .BITS   (BITS),
    .SIGNED (SIGNED)
  ) u_mult (
    .a_i (a),
    .b_i (b),
    .p_o (w_prod)
  );

  assign w_advance = !s2_valid_q || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

  // One extra bit on the MAC sum exposes overflow out of the accumulator width.
  generate
    if (SIGNED != 0) begin : g_sext
      assign w_prod_ext = AW'($signed(s1_prod_q));
      assign w_c_ext    = AW'($signed(s1_c_q));
      assign w_acc_x    = {acc_q[AW-1], acc_q};
      assign w_prod_x   = {w_prod_ext[AW-1], w_prod_ext};
      assign w_mac_ovf  = w_sum_x[AW] ^ w_sum_x[AW-1];
    end else begin : g_zext
      assign w_prod_ext = AW'(s1_prod_q);
      assign w_c_ext    = AW'(s1_c_q);
      assign w_acc_x    = {1'b0, acc_q};
      assign w_prod_x   = {1'b0, w_prod_ext};
      assign w_mac_ovf  = w_sum_x[AW];
    end
  endgenerate

  assign w_sum_x = w_acc_x + w_prod_x;

`ifdef MAC_PIPE_SAT_EN
  always_comb begin
    w_mac_val = w_sum_x[AW-1:0];
    if (w_mac_ovf) begin
      if (SIGNED != 0) begin
        w_mac_val = w_sum_x[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end else begin
        w_mac_val = '1;
      end
    end
  end
`else
  assign w_mac_val = w_sum_x[AW-1:0];
`endif

  always_comb begin
    result_d = w_prod_ext;
    ovf_d    = 1'b0;
    acc_d    = acc_q;
    case (s1_op_q)
      OP_MADD:  result_d = w_prod_ext + w_c_ext;
      OP_MAC: begin
        result_d = w_mac_val;
        ovf_d    = w_mac_ovf;
        acc_d    = w_mac_val;
      end
      OP_MACLD: acc_d = w_prod_ext;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_c_q     <= '0;
      s1_op_q    <= OP_MUL;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
    end else if (w_advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_prod_q <= w_prod;
        s1_c_q    <= c;
        s1_op_q   <= op_e'(func);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        acc_q    <= acc_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 The block SHALL have parameter BITS, default 32, the operand width of A, B and C.
REQ-002 The block SHALL have parameter GUARD, default 8, the extra accumulator bits above 2*BITS.
REQ-003 The block SHALL have parameter SIGNED, default 1, selecting two's-complement (1) or unsigned (0) arithmetic.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  operand bundle present.
REQ-007 in_ready  output  1  block accepts the bundle this cycle.
REQ-008 func  input  2  opcode: 00 MUL, 01 MADD, 10 MAC, 11 MACLD.
REQ-009 a, b, c  input  BITS each  operands.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  2*BITS+GUARD  result, sign- or zero-extended per SIGNED.
REQ-013 ovf  output  1  overflow flag for the result on the output.

Function
REQ-014 A transfer SHALL occur on each edge where valid and ready are both high, on input and on output.
REQ-015 The pipeline SHALL have two register stages: S1 holds a*b, c and func; S2 holds result.
- Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready stays high.
REQ-016 Throughput SHALL be one operation per cycle with no bubbles while out_ready is high.
REQ-017 Stall: the pipeline SHALL advance only when !out_valid || out_ready.
- in_ready SHALL equal that advance condition.
- Held stages SHALL keep their contents unchanged.
REQ-018 MUL SHALL produce result = a*b.
REQ-019 MADD SHALL produce result = a*b + ext(c), with c extended per SIGNED.
REQ-020 MAC SHALL produce acc = acc + a*b, and result = new acc.
REQ-021 MACLD SHALL produce acc = a*b, and result = new acc.
REQ-022 MUL and MADD SHALL leave acc unchanged.
REQ-023 acc SHALL be 2*BITS+GUARD wide and SHALL update in S2 only, when an S1 entry advances.
- Back-to-back MACs SHALL therefore chain without a hazard.
REQ-024 ovf SHALL assert when the true MAC sum does not fit the accumulator width.
- Without saturation, result SHALL wrap modulo 2^(2*BITS+GUARD).
- ovf SHALL be 0 for MUL, MADD and MACLD.
REQ-025 A bubble (S1 invalid) SHALL NOT modify acc.

Reset
REQ-026 rst_n low SHALL immediately clear: S1/S2 valid bits, acc, result and ovf.
- in_ready SHALL then read 1.
REQ-027 Reset mid-operation SHALL discard in-flight entries; no out_valid SHALL appear from them after release.
REQ-028 The first edge after release SHALL accept input normally.

Configuration
REQ-029 With MAC_PIPE_SAT_EN defined, MAC overflow SHALL clamp acc and result to the max/min representable value and SHALL set ovf.
REQ-030 Without MAC_PIPE_SAT_EN, overflow SHALL wrap per REQ-024; no saturation logic SHALL be present.

Structure
REQ-031 Package mac_pipe_pkg SHALL hold:
- the opcode enum (OP_MUL, OP_MADD, OP_MAC, OP_MACLD);
- the function returning accumulator width from BITS and GUARD.
REQ-032 The multiplier SHALL be a sub-module mac_mult, combinational, BITS x BITS -> 2*BITS, honouring SIGNED.
- Its output SHALL be registered into S1 by mac_pipe.

Verification
REQ-033 MUL, BITS=8, SIGNED=1: a=-3, b=7 -> result=-21 exactly 2 cycles after the transfer; ovf=0.
REQ-034 MADD: a=5, b=6, c=-10 -> 20; acc unchanged, checked by a following MAC a=0.
REQ-035 MACLD 2*3 then MAC 4*5 and MAC 1*1 back-to-back -> results 6, 26, 27 on consecutive cycles.
REQ-036 out_ready low for 3 cycles with 2 ops in flight:
- in_ready=0;
- result held stable;
- both results delivered in order after release, none lost or duplicated.
REQ-037 GUARD=0, BITS=8, SIGNED=1, repeated MAC 127*127:
- with MAC_PIPE_SAT_EN: saturates at 32767, ovf=1;
- without it: wraps, ovf=1.
REQ-038 rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately, acc=0, no stale output after release.
